// File: rtl/mouse_pkg.sv
// Shared constants and types for the mouse cursor tracker: delta width,
// internal sum headroom and the Q display mode encodings.
package mouse_pkg;
    localparam int DELTA_W = 9;
    localparam int SUM_PAD = 12;

    typedef enum logic [1:0] {
        MODE_BUTTONS = 2'd0,
        MODE_XPOS    = 2'd1,
        MODE_YPOS    = 2'd2,
        MODE_COUNT   = 2'd3
    } mode_e;

    function automatic int sum_width(input int pos_width);
        return pos_width + SUM_PAD;
    endfunction
endpackage

// File: rtl/axis_accumulator.sv
// One cursor axis: registers the sign-extended, shifted delta (stage 1) and
// applies it to the clamped position one cycle later (stage 2).
module axis_accumulator
    import mouse_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int MAX      = 639,
    parameter int SHIFT    = 0,
    parameter int SUBTRACT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DELTA_W-1:0] delta,
    input  logic               update,
    input  logic               center,
    output logic [WIDTH-1:0]   pos
);
    localparam int SUM_W = sum_width(WIDTH);
    localparam logic [WIDTH-1:0]        MID   = WIDTH'(MAX >> 1);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] delta_s1;
    logic signed [SUM_W-1:0] pos_ext;
    logic signed [SUM_W-1:0] sum;
    logic [WIDTH-1:0]        pos_next;

    assign delta_ext = {{(SUM_W - DELTA_W){delta[DELTA_W-1]}}, delta} <<< SHIFT;
    assign pos_ext   = {{SUM_PAD{1'b0}}, pos};

    // SUM_PAD bits of headroom keep the sum from wrapping before the clamp.
    always_comb begin
        sum = (SUBTRACT != 0) ? (pos_ext - delta_s1) : (pos_ext + delta_s1);
        if (sum[SUM_W-1])
            pos_next = '0;
        else if (sum > MAX_S)
            pos_next = MAX_S[WIDTH-1:0];
        else
            pos_next = sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_s1 <= '0;
            pos      <= MID;
        end else begin
            if (load)
                delta_s1 <= delta_ext;
            if (center)
                pos <= MID;
            else if (update)
                pos <= pos_next;
        end
    end
endmodule

// File: rtl/mouse_cursor_tracker.sv
// Two-stage mouse packet tracker: clamped cursor position, click edge pulses,
// accepted-packet counter and a registered LED display byte.
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int POS_WIDTH   = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int SPEED_SHIFT = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PacketValid,
    input  logic                 LeftButton,
    input  logic                 RightButton,
    input  logic [DELTA_W-1:0]   XDelta,
    input  logic [DELTA_W-1:0]   YDelta,
    input  logic                 Center,
    input  logic [1:0]           Mode,
    output logic [POS_WIDTH-1:0] XPos,
    output logic [POS_WIDTH-1:0] YPos,
    output logic                 LeftClick,
    output logic                 RightClick,
    output logic [7:0]           PacketCount,
    output logic [7:0]           Q
);
    logic valid_s1, left_s1, right_s1;
    logic left_s, right_s;
    logic [7:0] q_next;

    axis_accumulator #(
        .WIDTH(POS_WIDTH), .MAX(X_MAX), .SHIFT(SPEED_SHIFT), .SUBTRACT(0)
    ) u_x (
        .clk(Clk), .rst_n(Reset), .load(PacketValid), .delta(XDelta),
        .update(valid_s1), .center(Center), .pos(XPos)
    );

    // Y grows downward on screen, so positive (up) deltas are subtracted.
    axis_accumulator #(
        .WIDTH(POS_WIDTH), .MAX(Y_MAX), .SHIFT(SPEED_SHIFT), .SUBTRACT(1)
    ) u_y (
        .clk(Clk), .rst_n(Reset), .load(PacketValid), .delta(YDelta),
        .update(valid_s1), .center(Center), .pos(YPos)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_s1 <= 1'b0;
            left_s1  <= 1'b0;
            right_s1 <= 1'b0;
        end else begin
            valid_s1 <= PacketValid;
            if (PacketValid) begin
                left_s1  <= LeftButton;
                right_s1 <= RightButton;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            left_s      <= 1'b0;
            right_s     <= 1'b0;
            LeftClick   <= 1'b0;
            RightClick  <= 1'b0;
            PacketCount <= 8'd0;
        end else begin
            LeftClick  <= valid_s1 & left_s1 & ~left_s;
            RightClick <= valid_s1 & right_s1 & ~right_s;
            if (valid_s1) begin
                left_s      <= left_s1;
                right_s     <= right_s1;
                PacketCount <= PacketCount + 8'd1;
            end
        end
    end

    always_comb begin
        q_next = 8'd0;
        case (mode_e'(Mode))
            MODE_BUTTONS: q_next = {right_s, left_s, XPos[2:0], YPos[2:0]};
            MODE_XPOS:    q_next = XPos[POS_WIDTH-1 -: 8];
            MODE_YPOS:    q_next = YPos[POS_WIDTH-1 -: 8];
            MODE_COUNT:   q_next = PacketCount;
            default:      q_next = 8'd0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Q <= 8'd0;
        else
            Q <= q_next;
    end
endmodule
